// File: rtl/fifo_read_port_if.sv
// Read-side bus of an asynchronous FIFO.
// Carries the synchronized write pointer and the memory read path into the
// read port, and the read address, Gray read pointer and output word stage
// back out.
//   master : the read port itself (drives r_addr, r_ptr_gray, r_empty,
//            dout, dout_valid)
//   slave  : memory / consumer / synchronizer side (drives w_ptr_gray_sync,
//            r_data, dout_ready)
interface fifo_read_port_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH:0]   w_ptr_gray_sync;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_ptr_gray;
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        input  w_ptr_gray_sync, r_data, dout_ready,
        output r_addr, r_ptr_gray, r_empty, dout, dout_valid
    );

    modport slave (
        output w_ptr_gray_sync, r_data, dout_ready,
        input  r_addr, r_ptr_gray, r_empty, dout, dout_valid
    );
endinterface

// File: rtl/fifo_read_port.sv
// Read port of an asynchronous FIFO.
// Keeps the binary read pointer, publishes its Gray form for the write
// domain, derives a registered empty flag from the synchronized write
// pointer, and feeds a one-word registered output stage with a
// valid/ready handshake.
// Ports:
//   r_clk : read-domain clock, rising edge
//   r_rst : asynchronous active-high reset
//   bus   : fifo_read_port_if.master (see interface for signal list)
module fifo_read_port #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             r_clk,
    input  logic             r_rst,
    fifo_read_port_if.master bus
);
    logic [ADDR_WIDTH:0]   r_bin;
    logic [ADDR_WIDTH:0]   r_bin_next;
    logic [ADDR_WIDTH:0]   r_gray_next;
    logic [ADDR_WIDTH:0]   r_ptr_gray_q;
    logic                  r_empty_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  slot_free;
    logic                  pop;

    // A pop only happens when the output stage can take the word and the
    // registered empty flag says one exists, so underflow cannot occur.
    assign slot_free   = !dout_valid_q || bus.dout_ready;
    assign pop         = slot_free && !r_empty_q;
    assign r_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, pop};
    assign r_gray_next = r_bin_next ^ (r_bin_next >> 1);

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_bin        <= '0;
            r_ptr_gray_q <= '0;
            r_empty_q    <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            r_bin        <= r_bin_next;
            r_ptr_gray_q <= r_gray_next;
            // Compare the post-pop pointer against this cycle's write pointer,
            // full width so the lap bit separates empty from full.
            r_empty_q    <= (r_gray_next == bus.w_ptr_gray_sync);
            if (pop) begin
                dout_q       <= bus.r_data;
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.r_addr     = r_bin[ADDR_WIDTH-1:0];
    assign bus.r_ptr_gray = r_ptr_gray_q;
    assign bus.r_empty    = r_empty_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench for fifo_read_port: a per-cycle vector table for the
// streaming / stall / consume cases, plus hand-written sequences for reset,
// wrap-around and full-memory drain.
module tb_fifo_read_port;
    logic r_clk;
    logic r_rst;
    logic [3:0] mem [16];

    fifo_read_port_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) bus ();

    fifo_read_port #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .bus   (bus.master)
    );

    assign bus.r_data = mem[bus.r_addr];

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_empty, input logic e_valid,
                           input logic [3:0] e_dout, input logic [3:0] e_addr,
                           input logic [4:0] e_gray);
        chk({tag, " r_empty"},    32'(bus.r_empty),    32'(e_empty));
        chk({tag, " dout_valid"}, 32'(bus.dout_valid), 32'(e_valid));
        chk({tag, " dout"},       32'(bus.dout),       32'(e_dout));
        chk({tag, " r_addr"},     32'(bus.r_addr),     32'(e_addr));
        chk({tag, " r_ptr_gray"}, 32'(bus.r_ptr_gray), 32'(e_gray));
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // Asynchronous reset pulse placed 2 ns after the last sample point,
    // i.e. well away from any rising edge; outputs checked while it is held.
    task automatic reset_pulse(input string tag);
        #2 r_rst = 1'b1;
        #1 chk_all(tag, 1'b1, 1'b0, 4'd0, 4'd0, 5'b00000);
        #2 r_rst = 1'b0;
    endtask

    typedef struct packed {
        logic       ready;
        logic [4:0] wptr;
        logic       e_empty;
        logic       e_valid;
        logic [3:0] e_dout;
        logic [3:0] e_addr;
        logic [4:0] e_gray;
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];
    logic [3:0] exp_full [16];

    initial begin
        // mem[i] = (7*i+3) mod 16: 3,A,1,8,F,6,D,4,B,2,9,0,7,E,5,C
        for (int i = 0; i < 16; i++) mem[i] = 4'((7 * i + 3) % 16);
        exp_full = '{4'h3, 4'hA, 4'h1, 4'h8, 4'hF, 4'h6, 4'hD, 4'h4,
                     4'hB, 4'h2, 4'h9, 4'h0, 4'h7, 4'hE, 4'h5, 4'hC};

        //          ready wptr      empty valid dout   addr   gray
        vec[0]  = '{1'b1, 5'b00010, 1'b0, 1'b0, 4'h0, 4'd0, 5'b00000};
        vec[1]  = '{1'b1, 5'b00010, 1'b0, 1'b1, 4'h3, 4'd1, 5'b00001};
        vec[2]  = '{1'b1, 5'b00010, 1'b0, 1'b1, 4'hA, 4'd2, 5'b00011};
        vec[3]  = '{1'b1, 5'b00010, 1'b1, 1'b1, 4'h1, 4'd3, 5'b00010};
        vec[4]  = '{1'b1, 5'b00010, 1'b1, 1'b0, 4'h1, 4'd3, 5'b00010};
        vec[5]  = '{1'b1, 5'b00010, 1'b1, 1'b0, 4'h1, 4'd3, 5'b00010};
        vec[6]  = '{1'b0, 5'b00101, 1'b0, 1'b0, 4'h1, 4'd3, 5'b00010};
        vec[7]  = '{1'b0, 5'b00101, 1'b0, 1'b1, 4'h8, 4'd4, 5'b00110};
        vec[8]  = '{1'b0, 5'b00101, 1'b0, 1'b1, 4'h8, 4'd4, 5'b00110};
        vec[9]  = '{1'b0, 5'b00101, 1'b0, 1'b1, 4'h8, 4'd4, 5'b00110};
        vec[10] = '{1'b0, 5'b00101, 1'b0, 1'b1, 4'h8, 4'd4, 5'b00110};
        vec[11] = '{1'b0, 5'b00101, 1'b0, 1'b1, 4'h8, 4'd4, 5'b00110};
        vec[12] = '{1'b0, 5'b00101, 1'b0, 1'b1, 4'h8, 4'd4, 5'b00110};
        vec[13] = '{1'b1, 5'b00101, 1'b0, 1'b1, 4'hF, 4'd5, 5'b00111};
        vec[14] = '{1'b1, 5'b00101, 1'b1, 1'b1, 4'h6, 4'd6, 5'b00101};
        vec[15] = '{1'b0, 5'b00101, 1'b1, 1'b1, 4'h6, 4'd6, 5'b00101};
        vec[16] = '{1'b1, 5'b00101, 1'b1, 1'b0, 4'h6, 4'd6, 5'b00101};
        vec[17] = '{1'b1, 5'b00100, 1'b0, 1'b0, 4'h6, 4'd6, 5'b00101};
        vec[18] = '{1'b1, 5'b01100, 1'b0, 1'b1, 4'hD, 4'd7, 5'b00100};
        vec[19] = '{1'b0, 5'b01100, 1'b0, 1'b1, 4'hD, 4'd7, 5'b00100};

        // Reset held with the clock running.
        r_rst = 1'b1;
        bus.w_ptr_gray_sync = 5'b00000;
        bus.dout_ready = 1'b1;
        #23 chk_all("in_reset", 1'b1, 1'b0, 4'd0, 4'd0, 5'b00000);
        #4 r_rst = 1'b0;

        // Idle after reset with nothing written.
        for (int i = 0; i < 10; i++)
            chk_all($sformatf("idle%0d", i), 1'b1, 1'b0, 4'd0, 4'd0, 5'b00000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all($sformatf("idle_cyc%0d", i), 1'b1, 1'b0, 4'd0, 4'd0, 5'b00000);
        end

        // Stream / stall / consume / pointer-change-during-pop vectors.
        for (int i = 0; i < NV; i++) begin
            bus.dout_ready      = vec[i].ready;
            bus.w_ptr_gray_sync = vec[i].wptr;
            tick();
            chk_all($sformatf("vec%0d", i), vec[i].e_empty, vec[i].e_valid,
                    vec[i].e_dout, vec[i].e_addr, vec[i].e_gray);
        end

        // Reset while holding a word at r_bin=7; next pop must read address 0.
        reset_pulse("rst_mid");
        bus.w_ptr_gray_sync = 5'b00001;
        bus.dout_ready = 1'b1;
        tick();
        chk_all("rst_first_edge", 1'b0, 1'b0, 4'd0, 4'd0, 5'b00000);
        tick();
        chk_all("rst_first_pop", 1'b1, 1'b1, 4'h3, 4'd1, 5'b00001);

        // Wrap: drain 15 words, then 3 more across the 15->0 boundary.
        reset_pulse("rst_wrap");
        bus.w_ptr_gray_sync = 5'b01000;
        bus.dout_ready = 1'b1;
        repeat (18) tick();
        chk_all("wrap_at15", 1'b1, 1'b0, 4'h5, 4'd15, 5'b01000);
        bus.w_ptr_gray_sync = 5'b11011;
        tick();
        chk_all("wrap_ne", 1'b0, 1'b0, 4'h5, 4'd15, 5'b01000);
        tick();
        chk_all("wrap_rd15", 1'b0, 1'b1, 4'hC, 4'd0, 5'b11000);
        tick();
        chk_all("wrap_rd0", 1'b0, 1'b1, 4'h3, 4'd1, 5'b11001);
        tick();
        chk_all("wrap_rd1", 1'b1, 1'b1, 4'hA, 4'd2, 5'b11011);

        // Full memory: 16 words drained in order, empty only after the last.
        reset_pulse("rst_full");
        bus.w_ptr_gray_sync = 5'b11000;
        bus.dout_ready = 1'b1;
        tick();
        chk_all("full_ne", 1'b0, 1'b0, 4'd0, 4'd0, 5'b00000);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("full_dout%0d", k), 32'(bus.dout), 32'(exp_full[k]));
            chk($sformatf("full_valid%0d", k), 32'(bus.dout_valid), 32'd1);
            chk($sformatf("full_empty%0d", k), 32'(bus.r_empty), (k == 15) ? 32'd1 : 32'd0);
        end
        chk("full_gray_end", 32'(bus.r_ptr_gray), 32'(5'b11000));
        chk("full_addr_end", 32'(bus.r_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
